// File: rtl/nonce_sched_pkg.sv
// Shared types and constants for the nonce transmit scheduler.
`default_nettype none

package nonce_sched_pkg;

  localparam int NONCE_W       = 32;
  localparam int START_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/nonce_fifo.sv
// Synchronous FIFO, no bypass; a pushed entry becomes visible the cycle after the push.
`default_nettype none

module nonce_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nonce_tx_scheduler.sv
// Per-core capture slots, round-robin arbiter into a shared FIFO, and a TX sequencer.
// Optional DROP_COUNT_EN adds a saturating drop_count output.
`default_nettype none

module nonce_tx_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          nonce_valid,
  input  logic [NONCE_W*NUM_CORES-1:0]  nonce_in,
  input  logic                          flush,
  input  logic                          tx_busy,
  output logic                          tx_ready,
  output logic [NONCE_W-1:0]            word,
  output logic [NUM_CORES-1:0]          slot_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sched_busy
`ifdef DROP_COUNT_EN
  ,
  output logic [CNT_W-1:0]              drop_count
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TW    = $clog2(START_TIMEOUT) + 1;

  logic [NONCE_W-1:0]  slot_data [NUM_CORES];
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W:0]      scan_idx;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_found;
  logic                grant_en;
  logic [NUM_CORES-1:0] grant_vec;

  logic                fifo_full;
  logic                fifo_empty;
  logic [NONCE_W-1:0]  fifo_head;
  logic                pop;

  seq_state_t          state, state_nx;
  logic [TW-1:0]       timer, timer_nx;
  logic                tx_ready_nx;
  logic [NONCE_W-1:0]  word_nx;

  // A full FIFO can still accept the grant when the sequencer pops in the same cycle.
  assign grant_en = !flush && (!fifo_full || pop);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_CORES)) scan_idx = scan_idx - (PTR_W+1)'(NUM_CORES);
      if (grant_en && !grant_found && slot_pending[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      grant_vec[i] = grant_found && (grant_idx == PTR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_CORES-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // A slot granted this cycle is free again, so a same-cycle strobe reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_pending <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot_data[i] <= '0;
    end else if (flush) begin
      slot_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (nonce_valid[i] && (!slot_pending[i] || grant_vec[i])) begin
          slot_data[i]    <= nonce_in[NONCE_W*i +: NONCE_W];
          slot_pending[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          slot_pending[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DROP_COUNT_EN
  logic [NUM_CORES-1:0] drop_vec;
  logic [CNT_W+4:0]     drop_sum;
  logic [CNT_W-1:0]     drop_cnt;

  always_comb begin
    drop_vec = '0;
    drop_sum = {5'b0, drop_cnt};
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_vec[i] = nonce_valid[i] && slot_pending[i] && !grant_vec[i] && !flush;
      if (drop_vec[i]) drop_sum = drop_sum + (CNT_W+5)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_sum > {5'b0, {CNT_W{1'b1}}}) begin
      drop_cnt <= {CNT_W{1'b1}};
    end else begin
      drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  assign drop_count = drop_cnt;
`endif

  nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (grant_found),
    .push_data (slot_data[grant_idx]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    tx_ready_nx = 1'b0;
    word_nx     = word;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy && !flush) begin
          pop         = 1'b1;
          word_nx     = fifo_head;
          tx_ready_nx = 1'b1;
          timer_nx    = '0;
          state_nx    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (timer == TW'(START_TIMEOUT-1)) begin
          // Start strobe was missed: pulse again with the same word.
          tx_ready_nx = 1'b1;
          timer_nx    = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      tx_ready <= 1'b0;
      word     <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      tx_ready <= tx_ready_nx;
      word     <= word_nx;
    end
  end

  assign sched_busy = (|slot_pending) || !fifo_empty || (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_nonce_tx_scheduler.sv
// Randomized and directed bench for nonce_tx_scheduler against a queue-based reference model.
`default_nettype none

module tb_nonce_tx_scheduler;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      nonce_valid = '0;
  logic [32*N-1:0]   nonce_in = '0;
  logic              flush = 1'b0;
  logic              tx_busy = 1'b0;
  logic              tx_ready;
  logic [31:0]       word;
  logic [N-1:0]      slot_pending;
  logic [$clog2(D):0] fifo_count;
  logic              sched_busy;
`ifdef DROP_COUNT_EN
  logic [CW-1:0]     drop_count;
`endif

  always #5 clk = ~clk;

  nonce_tx_scheduler #(.NUM_CORES(N), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .nonce_valid  (nonce_valid),
    .nonce_in     (nonce_in),
    .flush        (flush),
    .tx_busy      (tx_busy),
    .tx_ready     (tx_ready),
    .word         (word),
    .slot_pending (slot_pending),
    .fifo_count   (fifo_count),
    .sched_busy   (sched_busy)
`ifdef DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: slots, a result queue and a transfer phase
  bit          m_pend [N];
  logic [31:0] m_slot [N];
  logic [31:0] m_q [$];
  int          m_ptr, m_phase, m_zeros, m_drops;
  bit          m_txr;
  logic [31:0] m_word;

  // Serial-core environment
  int          busy_left = 0, busy_len = 5;
  bit          arm = 0, stuck = 0, ignore_next = 0;
  logic [31:0] sent [$];

  task automatic model_update();
    bit pop, nxt_txr;
    bit old_pend [N];
    int g;
    if (reset) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_q.delete();
      m_ptr = 0; m_phase = 0; m_zeros = 0; m_drops = 0; m_txr = 0; m_word = '0;
      return;
    end
    pop = (m_phase == 0) && (m_q.size() > 0) && !tx_busy && !flush;
    g = -1;
    if (!flush && (m_q.size() < D || pop))
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++)
      if (nonce_valid[i] && m_pend[i] && g != i && !flush) m_drops++;
    nxt_txr = 0;
    case (m_phase)
      0: if (pop) begin m_word = m_q[0]; nxt_txr = 1; m_phase = 1; m_zeros = 0; end
      1: if (tx_busy) m_phase = 2;
         else begin
           m_zeros++;
           if (m_zeros == 4) begin nxt_txr = 1; m_zeros = 0; end
         end
      default: if (!tx_busy) m_phase = 0;
    endcase
    m_txr = nxt_txr;
    if (flush) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (g >= 0) m_q.push_back(m_slot[g]);
    end
    for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
    for (int i = 0; i < N; i++) begin
      if (flush) m_pend[i] = 0;
      else begin
        if (g == i) m_pend[i] = 0;
        if (nonce_valid[i] && (!old_pend[i] || g == i)) begin
          m_slot[i] = nonce_in[32*i +: 32];
          m_pend[i] = 1;
        end
      end
    end
    if (g >= 0) m_ptr = (g + 1) % N;
  endtask

  task automatic step();
    logic [N-1:0] pv;
    bit any;
    model_update();
    @(posedge clk);
    @(negedge clk);
    pv = '0; any = 0;
    for (int i = 0; i < N; i++) begin pv[i] = m_pend[i]; any |= m_pend[i]; end
    check_val("tx_ready", tx_ready, m_txr);
    check_val("word", word, m_word);
    check_val("fifo_count", fifo_count, m_q.size());
    check_val("slot_pending", slot_pending, pv);
    check_val("sched_busy", sched_busy, any || m_q.size() > 0 || m_phase != 0);
`ifdef DROP_COUNT_EN
    check_val("drop_count", drop_count, (m_drops > 255) ? 255 : m_drops);
`endif
    if (tx_ready === 1'b1) sent.push_back(word);
    if (arm) begin arm = 0; busy_left = busy_len; end
    if (tx_ready === 1'b1) begin
      if (ignore_next) ignore_next = 0;
      else if (busy_left == 0) arm = 1;
    end
    tx_busy = stuck || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    nonce_valid = '0; flush = 0; reset = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input int core, input logic [31:0] val);
    nonce_valid[core] = 1'b1;
    nonce_in[32*core +: 32] = val;
  endtask

  task automatic do_reset();
    reset = 1; step();
    reset = 1; step();
  endtask

  function automatic bit was_sent(input logic [31:0] v);
    foreach (sent[i]) if (sent[i] == v) return 1;
    return 0;
  endfunction

  initial begin
    @(negedge clk);
    do_reset();

    // Single result with a long serial transfer
    busy_len = 40; sent.delete();
    strobe(2, 32'hDEADBEEF);
    run(70);
    check_val("single_count", sent.size(), 1);
    check_val("single_word", sent[0], 32'hDEADBEEF);

    // All cores strobe together; pointer starts at 0
    do_reset();
    busy_len = 3; sent.delete();
    for (int i = 0; i < N; i++) strobe(i, 32'h1000_0000 + i);
    run(80);
    check_val("fair_count", sent.size(), 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("fair_order%0d", i), sent[i], 32'h1000_0000 + i);
    strobe(1, 32'h1000_0011); strobe(3, 32'h1000_0013);
    run(50);

    // Drop: FIFO full and busy stuck, second strobe on core 0 is lost
    do_reset();
    stuck = 1; tx_busy = 1; sent.delete();
    for (int k = 0; k < 8; k++) begin strobe((k % 3) + 1, 32'h100 + k); step(); end
    strobe(0, 32'hA); step();
    strobe(0, 32'hB); step();
`ifdef DROP_COUNT_EN
    check_val("drop_count_one", drop_count, 1);
`endif
    stuck = 0; busy_len = 4;
    run(200);
    check_val("drop_A_sent", was_sent(32'hA), 1);
    check_val("drop_B_lost", was_sent(32'hB), 0);

    // FIFO full: 12 results, 8 queued and 4 held in slots
    do_reset();
    stuck = 1; tx_busy = 1;
    for (int k = 0; k < 12; k++) begin strobe(k % 4, 32'h2000 + k); step(); end
    run(3);
    check_val("full_fifo_count", fifo_count, 8);
    check_val("full_slots", slot_pending, 4'hF);
    stuck = 0; busy_len = 4; sent.delete();
    run(250);
    check_val("full_sent_count", sent.size(), 12);
    for (int k = 0; k < 12; k++) check_val($sformatf("full_order%0d", k), sent[k], 32'h2000 + k);

    // Lost start: first strobe ignored, retry carries the same word
    do_reset();
    busy_len = 6; ignore_next = 1; sent.delete();
    strobe(1, 32'hCAFEF00D);
    run(40);
    check_val("lost_pulses", sent.size(), 2);
    check_val("lost_word0", sent[0], 32'hCAFEF00D);
    check_val("lost_word1", sent[1], 32'hCAFEF00D);

    // Flush during WAIT_DONE
    do_reset();
    busy_len = 30; sent.delete();
    for (int i = 0; i < 3; i++) strobe(i, 32'h3000 + i);
    run(9);
    flush = 1; step();
    run(60);
    check_val("flush_sent", sent.size(), 1);
    check_val("flush_fifo", fifo_count, 0);

    // Reset during WAIT_DONE
    do_reset();
    sent.delete();
    for (int i = 0; i < 3; i++) strobe(i, 32'h4000 + i);
    run(9);
    reset = 1; step();
    check_val("rst_tx_ready", tx_ready, 0);
    run(60);
    check_val("rst_sent", sent.size(), 1);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) < 2) strobe(i, $urandom);
      if ($urandom_range(0, 99) == 0) flush = 1;
      if ($urandom_range(0, 499) == 0) reset = 1;
      if ($urandom_range(0, 9) == 0 && !ignore_next) ignore_next = 1;
      if ($urandom_range(0, 199) == 0) stuck = ~stuck;
      busy_len = $urandom_range(1, 8);
      step();
    end
    stuck = 0;
    run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
